// File: rtl/btn_conditioner.sv
// Per-button synchroniser, tick-sampled debouncer and press/release/long-press pulse generator.
// Auto-repeat pulses after a long press are built only when BTN_REPEAT_EN is defined.
module btn_conditioner #(
    parameter int NBTN         = 4,
    parameter int TICK_MAX     = 1250000 - 1,
    parameter int STABLE_TICKS = 3,
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NBTN-1:0] i_btn,
    output logic [NBTN-1:0] o_level,
    output logic [NBTN-1:0] o_press,
    output logic [NBTN-1:0] o_release,
    output logic [NBTN-1:0] o_long_press,
    output logic [NBTN-1:0] o_repeat
);
    localparam int DW = $clog2(STABLE_TICKS + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);

    typedef enum logic [1:0] {
        ST_REL,
        ST_HELD,
        ST_LONG
    } state_t;

    logic [NBTN-1:0] r_sync1;
    logic [NBTN-1:0] r_sync2;
    logic [31:0]     r_tcnt;
    logic            w_tick;

    assign w_tick = (r_tcnt == 32'(TICK_MAX));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_tcnt  <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_tcnt  <= w_tick ? '0 : r_tcnt + 32'd1;
        end
    end

    for (genvar g = 0; g < NBTN; g++) begin : g_btn
        state_t        r_state;
        logic          r_level;
        logic          r_press;
        logic          r_release;
        logic          r_long;
        logic [DW-1:0] r_dcnt;
        logic [HW-1:0] r_hcnt;
        logic          w_diff;
        logic          w_flip;

        assign w_diff = r_sync2[g] ^ r_level;
        assign w_flip = w_tick & w_diff & (r_dcnt == DW'(STABLE_TICKS - 1));

        // State always tracks r_level: RELEASED iff level is 0.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_state   <= ST_REL;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;
                r_dcnt    <= '0;
                r_hcnt    <= '0;
            end else begin
                r_press   <= w_flip & ~r_level;
                r_release <= w_flip & r_level;
                r_long    <= 1'b0;
                if (w_tick) begin
                    r_dcnt <= (w_diff && !w_flip) ? r_dcnt + 1'b1 : '0;
                end
                if (w_flip) begin
                    r_level <= ~r_level;
                end
                case (r_state)
                    ST_HELD, ST_LONG: begin
                        if (w_flip) begin
                            r_state <= ST_REL;
                            r_hcnt  <= '0;
                        end else if (w_tick && r_state == ST_HELD) begin
                            r_hcnt <= r_hcnt + 1'b1;
                            if (r_hcnt == HW'(LONG_TICKS - 1)) begin
                                r_long  <= 1'b1;
                                r_state <= ST_LONG;
                            end
                        end
                    end
                    default: begin
                        r_hcnt <= '0;
                        if (w_flip) begin
                            r_state <= ST_HELD;
                        end
                    end
                endcase
            end
        end

        assign o_level[g]      = r_level;
        assign o_press[g]      = r_press;
        assign o_release[g]    = r_release;
        assign o_long_press[g] = r_long;

`ifdef BTN_REPEAT_EN
        localparam int RW = $clog2(REPEAT_TICKS + 1);
        logic [RW-1:0] r_rcnt;
        logic          r_repeat;

        // Zero outside LONG, so the count restarts at each long press.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_rcnt   <= '0;
                r_repeat <= 1'b0;
            end else begin
                r_repeat <= 1'b0;
                if (r_state != ST_LONG || w_flip) begin
                    r_rcnt <= '0;
                end else if (w_tick) begin
                    if (r_rcnt == RW'(REPEAT_TICKS - 1)) begin
                        r_rcnt   <= '0;
                        r_repeat <= 1'b1;
                    end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
            end
        end

        assign o_repeat[g] = r_repeat;
`else
        assign o_repeat[g] = 1'b0;
`endif
    end
endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

- Per-button front-end that feeds the run/pause and counter logic on the board.
- Synchronises raw push-button inputs, removes contact chatter with a tick-sampled stability filter, and delivers clean levels plus single-cycle press, release, long-press and (optionally) auto-repeat pulses.
- Downstream stages consume `press` directly as their toggle/step event and need no edge detection of their own.

## Interface
Parameters:
- `NBTN`, 4, number of independent buttons
- `TICK_MAX`, 1250000-1, sample-tick divider terminal value (10 ms at 125 MHz)
- `STABLE_TICKS`, 3, consecutive differing samples required to accept a new level
- `LONG_TICKS`, 100, held ticks after press before `long_press` fires (1 s)
- `REPEAT_TICKS`, 20, tick period of `repeat` pulses after long press (200 ms)

Ports:
- Clock/reset: one clock; reset is synchronous and active-high.
- `clk` input 1: system clock, all logic on rising edge
- `rst` input 1: synchronous active-high reset
- `btn` input NBTN: raw asynchronous button levels, 1 = pressed
- `level` output NBTN: debounced button state
- `press` output NBTN: one-cycle pulse on accepted 0→1
- `release` output NBTN: one-cycle pulse on accepted 1→0
- `long_press` output NBTN: one-cycle pulse when held `LONG_TICKS` ticks
- `repeat` output NBTN: one-cycle auto-repeat pulses (see Configuration)

## Operation
- Synchroniser: each `btn` bit passes through 2 flip-flops; only the second stage (`s`) is used downstream.
- Tick generator: shared 32-bit `tcnt` counts 0..`TICK_MAX`, then wraps to 0. `tick` = (`tcnt`==`TICK_MAX`), combinational.
- Debounce, per button, with a counter `dcnt`:
  - On tick with `s`==`level`: `dcnt`←0.
  - On tick with `s`!=`level`: if `dcnt`==`STABLE_TICKS`-1, `level` flips and `dcnt`←0; otherwise `dcnt`++.
  - Non-tick cycles leave `dcnt` unchanged.
- Edge outputs: `press`/`release` are registered and asserted for exactly the cycle after the flip edge. They are never both high for one button.
- Hold counter `hcnt`, per button, saturating:
  - Cleared on press flip and whenever `level`=0.
  - On each tick while `level`=1 (excluding the press tick itself), `hcnt`++.
  - When `hcnt` becomes `LONG_TICKS`, `long_press` pulses once. It does not re-fire until release and a fresh press.
- Release before `LONG_TICKS` produces no `long_press`.
- Buttons are fully independent. Simultaneous events on different buttons produce simultaneous pulses.
- Per-button state: RELEASED → (press flip) HELD → (`hcnt`==`LONG_TICKS`) LONG → (release flip) RELEASED. HELD → (release flip) RELEASED.

## Timing
- Reset values: all outputs 0. `tcnt`, `dcnt`, `hcnt`, `rcnt` are 0. Synchroniser flops are 0.
- First tick occurs `TICK_MAX` cycles after reset deassertion.
- Latency from a stable `btn` change to a `level` change:
  - 2 synchroniser cycles, plus
  - wait to the next tick, plus
  - (`STABLE_TICKS`-1) further ticks, plus
  - 1 register cycle.
- All pulse outputs are one `clk` wide, registered, aligned with the cycle `level` changes (press) or the cycle after the qualifying tick.
- Reset mid-operation: outputs drop to 0 in the cycle after `rst` is sampled high. A button still held after reset re-qualifies from scratch and emits a fresh `press`.
- Width rules: `dcnt` holds at least `STABLE_TICKS`. `hcnt` saturates at `LONG_TICKS` and never wraps.

## Configuration
- Macro: `BTN_REPEAT_EN`.
- Defined:
  - Per-button `rcnt` cleared at `long_press`.
  - In LONG state, each tick increments `rcnt`. When `rcnt` reaches `REPEAT_TICKS`, `repeat` pulses and `rcnt`←0.
  - Release clears `rcnt`.
- Undefined: `repeat` is tied to 0 and no `rcnt` logic is built. All other behaviour is identical.

## Test plan
Use `TICK_MAX`=3, `STABLE_TICKS`=3, `LONG_TICKS`=5, `REPEAT_TICKS`=2, `NBTN`=2.
- Bounce: `btn[0]` high for 6 cycles spanning 1 tick, then low → `level`, `press` stay 0 throughout.
- Clean press: `btn[0]` high ≥16 cycles → exactly one `press[0]` pulse. `level[0]`=1 after 3 consecutive high ticks. No `release`.
- Release then long press:
  - Hold `btn[0]` for 5 ticks past the press tick, then release → one `long_press[0]` on the 5th tick.
  - After release qualifies: one `release[0]`, and `level[0]`=0.
- Repeat, with `BTN_REPEAT_EN`: keep holding after long → `repeat[0]` every 2 ticks, one cycle wide. Without the macro → `repeat` never rises.
- Reset mid-hold: assert `rst` 1 cycle while `level[0]`=1 and the button is held → all outputs 0 next cycle. A new `press[0]` follows 3 ticks later; no `long_press` carried over.
- Simultaneous: `btn[0]` and `btn[1]` rise in the same cycle → `press[0]` and `press[1]` pulse in the same cycle. Releasing only `btn[1]` leaves button 0 unaffected.
